// File: rtl/inverse_mod_if.sv
// Handshake/bus bundle for the sequential modular inverse unit.
//   opA, opM   : operand and (odd) modulus, driven by the requester
//   in_valid   : single-cycle start pulse
//   out_data   : inverse result, held until the next accepted request
//   out_valid  : one-cycle result pulse
//   out_err    : non-invertible flag, valid with out_valid
//   busy       : operation in flight
interface inverse_mod_if #(
  parameter int unsigned DATA_WIDTH = 192
);
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opM;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_err;
  logic                  busy;

  modport master (
    output opA, opM, in_valid,
    input  out_data, out_valid, out_err, busy
  );

  modport slave (
    input  opA, opM, in_valid,
    output out_data, out_valid, out_err, busy
  );
endinterface

// File: rtl/inverse_mod.sv
// Sequential modular inverse: out_data = opA^-1 mod opM via the binary
// extended Euclidean algorithm, one reduction step per clock.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (aborts any operation)
//   bus    : inverse_mod_if.slave (opA, opM, in_valid -> out_data,
//            out_valid, out_err, busy)
// Configuration macro INVMOD_ERR_EN: when defined, out_err reports
// non-invertible inputs; otherwise out_err is tied low (error cases still
// terminate with out_data = 0).
module inverse_mod #(
  parameter int unsigned DATA_WIDTH = 192
) (
  input  logic          clk,
  input  logic          rst_n,
  inverse_mod_if.slave  bus
);

  localparam int unsigned W = DATA_WIDTH;

`ifdef INVMOD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   u_q, v_q, m_q;
  logic [W-1:0]   x1_q, x2_q;
  logic [W-1:0]   out_data_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           err_q;

  // (x + (odd ? m : 0)) / 2, keeping the carry out of the add.
  function automatic logic [W-1:0] half_f(input logic [W-1:0] x,
                                          input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, m} : {(W+1){1'b0}});
    return s[W:1];
  endfunction

  // (a - b) mod m for a, b already in [0, m).
  function automatic logic [W-1:0] submod_f(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    return d[W-1:0];
  endfunction

  // Control, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      m_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            u_q        <= bus.opA;
            v_q        <= bus.opM;
            m_q        <= bus.opM;
            x1_q       <= W'(1);
            x2_q       <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= INIT;
          end
        end
        INIT: begin
          // u still holds opA; m holds opM.
          if (u_q == '0 || !m_q[0]) begin
            err_q       <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= STEP;
          end
        end
        STEP: begin
          if (u_q == W'(1)) begin
            out_data_q  <= x1_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (v_q == W'(1)) begin
            out_data_q  <= x2_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (u_q == '0 || v_q == '0) begin
            // Reached zero without hitting one: gcd is not 1.
            err_q       <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (!u_q[0]) begin
            u_q  <= u_q >> 1;
            x1_q <= half_f(x1_q, m_q);
          end else if (!v_q[0]) begin
            v_q  <= v_q >> 1;
            x2_q <= half_f(x2_q, m_q);
          end else if (u_q >= v_q) begin
            u_q  <= u_q - v_q;
            x1_q <= submod_f(x1_q, x2_q, m_q);
          end else begin
            v_q  <= v_q - u_q;
            x2_q <= submod_f(x2_q, x1_q, m_q);
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = ERR_EN & err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inverse_mod.sv
// Randomized self-checking bench for inverse_mod (DATA_WIDTH = 192).
// A number-theoretic model (gcd, modular product) judges each result;
// a few hand-derived literals pin the model and the latency.
module tb_inverse_mod;

  localparam int unsigned W = 192;
  localparam logic [W-1:0] P192 =
    192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;
  localparam logic [W-1:0] INV2_P192 =
    192'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_00000000;
  localparam int LAT_MAX = 4 * W + 4;
  localparam int LAT_TIMEOUT = 2000;

`ifdef INVMOD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] lit;
    bit           has_lit;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inverse_mod_if #(.DATA_WIDTH(W)) bus ();
  inverse_mod #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  op_t expq[$];
  logic [W-1:0] held = '0;
  logic held_err = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != '0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] mulmod_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  function automatic bit non_invertible(input logic [W-1:0] a, input logic [W-1:0] m);
    return (a == '0) || !m[0] || (gcd_f(a, m) != W'(1));
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Result checker: every out_valid is judged against the model; while idle
  // the held outputs must stay at the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        chk("pending_request", W'(expq.size() != 0), W'(1));
        if (expq.size() != 0) begin
          op_t op;
          bit e;
          op = expq.pop_front();
          e = non_invertible(op.a, op.m);
          chk("out_err", W'(bus.out_err), W'(ERR_EN & e));
          if (e) begin
            chk("data_on_error", bus.out_data, '0);
          end else begin
            chk("a_times_inv_mod_m", mulmod_f(op.a, bus.out_data, op.m), W'(1));
            chk("inv_below_m", W'(bus.out_data < op.m), W'(1));
          end
          if (op.has_lit) chk("data_literal", bus.out_data, op.lit);
        end
        held = bus.out_data;
        held_err = bus.out_err;
      end else if (!bus.busy) begin
        chk("held_data", bus.out_data, held);
        chk("held_err", W'(bus.out_err), W'(held_err));
      end
    end
  end

  // One request; exp_lat=0 checks only the bound. poke_at pulses a foreign
  // request while busy; rst_at aborts the operation with a reset.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m,
                        input bit has_lit, input logic [W-1:0] lit,
                        input int exp_lat, input int poke_at, input int rst_at);
    op_t op;
    int lat;
    op.a = a; op.m = m; op.lit = lit; op.has_lit = has_lit;
    @(negedge clk);
    expq.push_back(op);
    bus.opA = a; bus.opM = m; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 2;
    while (!bus.out_valid) begin
      if (lat == rst_at) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expq.delete();
        held = '0;
        held_err = 1'b0;
        #1;
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_out_err", W'(bus.out_err), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        repeat (3) begin
          @(negedge clk);
          chk("valid_in_reset", W'(bus.out_valid), W'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        return;
      end
      if (lat >= LAT_TIMEOUT) begin
        total++;
        bad++;
        $display("FAIL timeout waiting out_valid a=%h m=%h", a, m);
        return;
      end
      if (lat == poke_at) begin
        bus.opA = W'(1); bus.opM = W'(13); bus.in_valid = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end
    chk("latency_bound", W'(lat <= LAT_MAX), W'(1));
    if (exp_lat != 0) chk("latency", W'(lat), W'(exp_lat));
  endtask

  int primes[10] = '{3, 5, 7, 11, 13, 101, 251, 257, 65521, 2147483647};

  initial begin
    logic [W-1:0] ra, rm;
    bus.opA = '0; bus.opM = '0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_out_valid", W'(bus.out_valid), W'(0));
    chk("reset_out_err", W'(bus.out_err), W'(0));
    chk("reset_busy", W'(bus.busy), W'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Hand-derived cases.
    run_op(W'(5), W'(13), 1'b1, W'(8), 0, -1, -1);
    @(negedge clk);
    chk("busy_after_done", W'(bus.busy), W'(0));
    run_op(W'(1), W'(13), 1'b1, W'(1), 4, -1, -1);
    run_op(W'(6), W'(15), 1'b1, W'(0), 0, -1, -1);
    run_op(W'(6), W'(12), 1'b1, W'(0), 3, -1, -1);
    run_op(W'(0), W'(13), 1'b1, W'(0), 3, -1, -1);
    run_op(W'(2), P192, 1'b1, INV2_P192, 5, -1, -1);

    // A request in the DONE cycle is dropped.
    run_op(W'(3), W'(7), 1'b1, W'(5), 0, -1, -1);
    bus.opA = W'(1); bus.opM = W'(13); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_cycle_drop", W'(bus.busy), W'(0));
    repeat (3) @(negedge clk);
    chk("done_cycle_drop_late", W'(bus.busy), W'(0));

    // A request while busy is ignored.
    ra = rand_w() % P192;
    if (ra == '0) ra = W'(7);
    run_op(ra, P192, 1'b0, '0, 0, 2, -1);

    // Randomized, back to back.
    for (int i = 0; i < 30; i++) begin
      case (i % 4)
        0: begin
          rm = P192;
          ra = rand_w() % P192;
        end
        1: begin
          rm = W'(primes[$urandom_range(0, 9)]);
          ra = W'($urandom) % rm;
        end
        2: begin
          rm = W'(2 * $urandom_range(1, 30000) + 1);
          ra = W'($urandom) % rm;
        end
        default: begin
          rm = W'($urandom_range(2, 60000));
          ra = W'($urandom) % rm;
        end
      endcase
      run_op(ra, rm, 1'b0, '0, 0, -1, -1);
    end

    // Reset mid-STEP, then a fresh request.
    ra = rand_w() % P192;
    if (ra < W'(1000)) ra = ra + W'(123457);
    run_op(ra, P192, 1'b0, '0, 0, -1, 10);
    run_op(W'(5), W'(13), 1'b1, W'(8), 0, -1, -1);

    repeat (3) @(negedge clk);
    chk("no_lost_results", W'(expq.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
